// File: rtl/scytale_encryption.sv
// scytale_encryption: buffers plaintext until a start token, then streams it in scytale (column-major) order.
// Define SCYTALE_ENC_PAD_EN to replace unwritten positions with PAD_CHAR.
module scytale_encryption #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 KEY_WIDTH              = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA,
    parameter logic [D_WIDTH-1:0] PAD_CHAR               = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);
    localparam int LW = 2 * KEY_WIDTH;
    localparam int SW = LW + 1;
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int IW = $clog2(MAX_NOF_CHARS);
`ifdef SCYTALE_ENC_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ENCRYPT, DONE} state_t;

    state_t               state_q, state_d;
    logic [D_WIDTH-1:0]   buf_q [MAX_NOF_CHARS];
    logic [D_WIDTH-1:0]   buf_d [MAX_NOF_CHARS];
    logic [CW-1:0]        count_q, count_d;
    logic [LW-1:0]        j_q, j_d, k_q, k_d, l_q, l_d;
    logic [KEY_WIDTH-1:0] m_q, m_d;
    logic [D_WIDTH-1:0]   data_o_q, data_o_d;
    logic                 valid_o_q, valid_o_d, busy_q, busy_d;
    logic [LW-1:0]        l_in;
    logic [SW-1:0]        j_step;
    logic                 tok;

    assign l_in   = LW'(key_N) * LW'(key_M);
    assign j_step = {1'b0, j_q} + SW'(m_q);
    assign tok    = valid_i && data_i == START_ENCRYPTION_TOKEN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            buf_q     <= '{default: '0};
            count_q   <= '0;
            j_q       <= '0;
            k_q       <= '0;
            l_q       <= '0;
            m_q       <= '0;
            data_o_q  <= '0;
            valid_o_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            j_q       <= j_d;
            k_q       <= k_d;
            l_q       <= l_d;
            m_q       <= m_d;
            data_o_q  <= data_o_d;
            valid_o_q <= valid_o_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && tok)
            state_d = (l_in == '0 || l_in > LW'(MAX_NOF_CHARS)) ? DONE : ENCRYPT;
        else if (state_q == ENCRYPT && k_q == l_q - 1'b1)
            state_d = DONE;
        else if (state_q == DONE)
            state_d = IDLE;
    end

    always_comb begin
        buf_d     = buf_q;
        count_d   = count_q;
        j_d       = j_q;
        k_d       = k_q;
        l_d       = l_q;
        m_d       = m_q;
        data_o_d  = '0;
        valid_o_d = 1'b0;
        busy_d    = busy_q;
        if (state_q == IDLE) begin
            if (tok) begin
                l_d    = l_in;
                m_d    = key_M;
                busy_d = 1'b1;
                j_d    = '0;
                k_d    = '0;
            end else if (valid_i && count_q < CW'(MAX_NOF_CHARS)) begin
                buf_d[count_q] = data_i;
                count_d        = count_q + 1'b1;
            end
        end else if (state_q == ENCRYPT) begin
            data_o_d  = (PAD_EN && j_q >= LW'(count_q)) ? PAD_CHAR : buf_q[j_q[IW-1:0]];
            valid_o_d = 1'b1;
            k_d       = k_q + 1'b1;
            // stepping by M wraps to the next column once past the end of the grid
            j_d       = (j_step >= {1'b0, l_q}) ? LW'(j_step - {1'b0, l_q} + 1'b1) : LW'(j_step);
        end else begin
            busy_d  = 1'b0;
            count_d = '0;
            buf_d   = '{default: '0};
        end
    end

    assign data_o  = data_o_q;
    assign valid_o = valid_o_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_scytale_encryption.sv
// tb_scytale_encryption: randomized scoreboard bench with a grid-based scytale reference model.
module tb_scytale_encryption;
    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = '0;
    logic       valid_i = 1'b0;
    logic [7:0] key_N = '0;
    logic [7:0] key_M = '0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb[$];

`ifdef SCYTALE_ENC_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    scytale_encryption dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .key_N(key_N), .key_M(key_M), .data_o(data_o), .valid_o(valid_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (rst_n && valid_o) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got %0h expected none", data_o);
            end else begin
                e = sb.pop_front();
                check("beat", data_o, e);
            end
        end
    end

    // Reference: lay the message row-major into an N x M grid and read it column by column.
    task automatic expect_msg(input bq_t msg, input int n, input int m, output int beats);
        int l, cnt, pos;
        l     = n * m;
        cnt   = msg.size() > 50 ? 50 : msg.size();
        beats = (l == 0 || l > 50) ? 0 : l;
        if (beats > 0)
            for (int c = 0; c < m; c++)
                for (int r = 0; r < n; r++) begin
                    pos = r * m + c;
                    sb.push_back(pos < cnt ? msg[pos] : (PAD ? 8'h20 : 8'h00));
                end
    endtask

    task automatic load_and_token(input bq_t msg, input int n, input int m, input bit junk, output int beats);
        foreach (msg[i]) begin
            if (junk && $urandom_range(3) == 0) begin
                valid_i = 1'b0;
                data_i  = 8'($urandom);
                @(posedge clk); #1;
            end
            valid_i = 1'b1;
            data_i  = msg[i];
            @(posedge clk); #1;
        end
        expect_msg(msg, n, m, beats);
        key_N   = 8'(n);
        key_M   = 8'(m);
        valid_i = 1'b1;
        data_i  = 8'hFA;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg, input int n, input int m, input bit junk);
        int beats, hi;
        load_and_token(msg, n, m, junk, beats);
        hi = 0;
        while (busy && hi < 300) begin
            hi++;
            if (junk) begin
                valid_i = 1'b1;
                data_i  = 8'($urandom);
                key_N   = 8'($urandom);
                key_M   = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        check("busy_cycles", hi, beats > 0 ? beats + 1 : 1);
        check("sb_drained", sb.size(), 0);
        sb.delete();
        check("idle_valid_o", valid_o, 0);
        check("idle_data_o", data_o, 0);
    endtask

    function automatic bq_t seq(input int first, input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'(first + i));
        return q;
    endfunction

    initial begin : stim
        bq_t msg;
        int  beats;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_data_o", data_o, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_msg(seq(8'h41, 6), 2, 3, 1'b0);
        send_msg(seq(8'h41, 6), 3, 2, 1'b0);
        send_msg(seq(8'h41, 4), 2, 3, 1'b0);
        send_msg(seq(8'h41, 4), 0, 3, 1'b0);
        send_msg(seq(8'h41, 6), 6, 10, 1'b0);
        send_msg(seq(8'h30, 0), 2, 2, 1'b0);
        send_msg(seq(8'h10, 55), 5, 10, 1'b0);
        send_msg(seq(8'h61, 9), 3, 3, 1'b1);

        load_and_token(seq(8'h41, 6), 2, 3, 1'b0, beats);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("arst_valid_o", valid_o, 0);
        check("arst_data_o", data_o, 0);
        check("arst_busy", busy, 0);
        check("beats_before_rst", sb.size(), 4);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_msg(seq(8'h51, 4), 2, 2, 1'b0);

        repeat (40) begin
            msg.delete();
            for (int i = 0, len = $urandom_range(0, 55); i < len; i++)
                msg.push_back(8'($urandom_range(0, 8'hF9)));
            send_msg(msg, $urandom_range(0, 8), $urandom_range(0, 8), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
